bcd_serial_add_ctrl: RTL and testbench
======================================

// Module: bcd_serial_add_ctrl
// PURPOSE
//  Digit-serial controller for multi-digit packed-BCD addition. Latches two
//  DIGITS-wide BCD operands on a start handshake and sequences one shared
//  4-bit BCD digit adder (carry chained) over them, least significant digit first.
//  Presents the registered sum, decimal carry and error flag with a one-cycle
//  done pulse. Serves as the area-lean replacement for wide parallel BCD adders.
// PARAMETERS
//  DIGITS   4   number of BCD digits per operand (>=1); operand width 4*DIGITS
// PORTS
//  clk        in   1          clock; all state changes on rising edge
//  rst_n      in   1          asynchronous active-low reset
//  start      in   1          request; sampled only in IDLE
//  a          in   4*DIGITS   operand A, packed BCD, digit 0 = bits [3:0]
//  b          in   4*DIGITS   operand B, packed BCD
//  sub        in   1          1 = A-B (BCD_SUB_EN only; otherwise ignored)
//  busy       out  1          high while in RUN
//  done       out  1          one-cycle pulse: sum/carry_out/err valid
//  sum        out  4*DIGITS   result, packed BCD
//  carry_out  out  1          decimal carry out of MS digit (sub: 1 = no borrow)
//  err        out  1          some latched operand nibble was > 9
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy=done=carry_out=err=0; sum=0; idx=0.
//  FSM: IDLE -> RUN on edge with start=1; RUN -> DONE after digit DIGITS-1;
//   DONE -> IDLE unconditionally next edge. start ignored in RUN and DONE (no queueing).
//  Accept edge k: latch a,b (and sub), idx=0, c=0 (c=1 if effective sub=1),
//   err=0 then set if any nibble of latched a or b > 9; sum cleared to 0.
//  Edges k+1..k+DIGITS: digit i=idx: bd = sub ? 9-b[i] : b[i];
//   t = a[i]+bd+c (5 bits); if t>9: sum[i]=(t+6)[3:0], c=1; else sum[i]=t, c=0;
//   idx++. sum nibbles update in place as digits complete.
//  Edge k+DIGITS: last digit written, carry_out<=c, state<=DONE.
//  done = (state==DONE): high exactly one cycle after edge k+DIGITS;
//   next start accepted at edge k+DIGITS+2 (issue interval DIGITS+2 cycles).
//  busy = (state==RUN). sum, carry_out, err hold after done until next accepted start.
//  Invalid nibbles (>9): same arithmetic rule applied mechanically to the
//   4-bit value; result unspecified but deterministic; err=1 until next accept.
//  idx counter width = clog2(DIGITS) (min 1); terminates at DIGITS-1, never wraps.
//  Operand inputs may change after the accept edge without effect.
//  rst_n low mid-RUN aborts the operation; no done pulse is produced for it.
// CONFIGURATION
//  BCD_SUB_EN defined: sub honoured; A-B computed as A + nines'(B) + 1 (tens'
//   complement); carry_out=1 -> result = A-B; carry_out=0 -> result is the
//   tens' complement of (B-A), i.e. negative.
//  BCD_SUB_EN undefined: sub port present but ignored; always A+B.
// TESTING (DIGITS=4)
//  a=4538,b=3829,start -> busy 4 cycles, done pulse, sum=8367, carry_out=0, err=0
//  a=9999,b=0001 -> sum=0000, carry_out=1; a=9999,b=9999 -> sum=9998, carry_out=1
//  BCD_SUB_EN: a=0045,b=0038,sub=1 -> sum=0007,c=1; a=0038,b=0045 -> sum=9993,c=0
//  a=00A0 (hex nibble A),b=0001 -> err=1 at done; next valid start clears err
//  start held high in RUN/DONE -> only one done per accept; toggle start mid-RUN
//   -> sum unaffected; rst_n low at 2nd RUN cycle -> all outputs 0, IDLE, no done

Source files
------------

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller: one shared 4-bit BCD digit adder swept LS digit first.
// Optional feature macro BCD_SUB_EN enables tens'-complement subtraction via the sub input.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  sub,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry_out,
  output logic                  err
);

  // state  | meaning
  // IDLE   | waiting for start; results from last operation held
  // RUN    | one digit per cycle, idx = digit being added
  // DONE   | results valid, done pulse; returns to IDLE next edge
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t state, state_nxt;

  logic [4*DIGITS-1:0] a_q, b_q;
  logic [IW-1:0]       idx;
  logic                c_q;
  logic                sub_eff;
  logic                bad_in;
  logic [3:0]          a_dig, b_dig, bd;
  logic [4:0]          t;
  logic [3:0]          s_dig;
  logic                c_nxt;
  logic                last_dig;

`ifdef BCD_SUB_EN
  logic sub_q;
  assign sub_eff = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_eff    = 1'b0;
`endif

  assign last_dig = (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_dig) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end
  end

  // Invalid nibbles go through the same rule; 9-b wraps modulo 16.
  always_comb begin
    a_dig = a_q[4*idx +: 4];
    b_dig = b_q[4*idx +: 4];
`ifdef BCD_SUB_EN
    bd = sub_q ? (4'd9 - b_dig) : b_dig;
`else
    bd = b_dig;
`endif
    t = {1'b0, a_dig} + {1'b0, bd} + {4'b0000, c_q};
    if (t > 5'd9) begin
      s_dig = 4'(t + 5'd6);
      c_nxt = 1'b1;
    end else begin
      s_dig = t[3:0];
      c_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      idx       <= '0;
      c_q       <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      err       <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= '0;
            c_q   <= sub_eff;
            err   <= bad_in;
            sum   <= '0;
`ifdef BCD_SUB_EN
            sub_q <= sub;
`endif
          end
        end
        S_RUN: begin
          sum[4*idx +: 4] <= s_dig;
          c_q             <= c_nxt;
          if (last_dig) carry_out <= c_nxt;
          else          idx       <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl: directed vectors plus randomized operands
// checked against a decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         busy, done, carry_out, err;
  logic [W-1:0] sum;

  int n_chk = 0;
  int n_err = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pow10_d();
    int m = 1;
    for (int i = 0; i < DIGITS; i++) m = m * 10;
    return m;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit all_valid(input logic [W-1:0] v);
    bit ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [W-1:0] rand_operand(input bit allow_bad);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 5) == 0)
      r[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
    return r;
  endfunction

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        input bit hold_start, input bit toggle);
    int busy_cnt = 0;
    bit got_done = 1'b0;
    bit valid;
    bit sub_m;
    int m, ai, bi, tot;
    logic [W-1:0] exp_sum;
    logic exp_c;

    valid = all_valid(av) && all_valid(bv);
`ifdef BCD_SUB_EN
    sub_m = sv;
`else
    sub_m = 1'b0;
`endif
    m  = pow10_d();
    ai = bcd2int(av);
    bi = bcd2int(bv);
    tot = sub_m ? (ai + (m - 1 - bi) + 1) : (ai + bi);
    exp_c   = (tot >= m);
    exp_sum = int2bcd(tot % m);

    @(negedge clk);
    chk_val("idle_busy", 32'(busy), 32'd0);
    a = av; b = bv; sub = sv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
    for (int cyc = 0; cyc < 3 * DIGITS + 4 && !got_done; cyc++) begin
      if (done) got_done = 1'b1;
      else begin
        if (busy) busy_cnt++;
        if (toggle) start = 1'($urandom);
        @(negedge clk);
      end
    end
    chk_val("done_seen", 32'(got_done), 32'd1);
    chk_val("busy_cycles", 32'(busy_cnt), 32'(DIGITS));
    chk_val("busy_at_done", 32'(busy), 32'd0);
    chk_val("err", 32'(err), valid ? 32'd0 : 32'd1);
    if (valid) begin
      chk_val("sum", 32'(sum), 32'(exp_sum));
      chk_val("carry_out", 32'(carry_out), 32'(exp_c));
    end
    @(negedge clk);
    start = 1'b0;
    chk_val("done_single", 32'(done), 32'd0);
    chk_val("busy_after", 32'(busy), 32'd0);
    chk_val("err_hold", 32'(err), valid ? 32'd0 : 32'd1);
    if (valid) chk_val("sum_hold", 32'(sum), 32'(exp_sum));
  endtask

  task automatic reset_mid_run();
    int n_done = 0;
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_val("rst_busy", 32'(busy), 32'd0);
    chk_val("rst_done", 32'(done), 32'd0);
    chk_val("rst_sum", 32'(sum), 32'd0);
    chk_val("rst_carry", 32'(carry_out), 32'd0);
    chk_val("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DIGITS + 3; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    chk_val("rst_no_done", 32'(n_done), 32'd0);
  endtask

  initial begin
    #2;
    chk_val("reset_busy", 32'(busy), 32'd0);
    chk_val("reset_done", 32'(done), 32'd0);
    chk_val("reset_sum", 32'(sum), 32'd0);
    chk_val("reset_carry", 32'(carry_out), 32'd0);
    chk_val("reset_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h4538, 16'h3829, 1'b0, 1'b0, 1'b0);
    run_op(16'h9999, 16'h9999, 1'b0, 1'b0, 1'b0);
    run_op(16'h00A0, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op(16'h1234, 16'h8766, 1'b0, 1'b1, 1'b0);
    run_op(16'h5555, 16'h4445, 1'b1, 1'b0, 1'b1);
`ifdef BCD_SUB_EN
    run_op(16'h0045, 16'h0038, 1'b1, 1'b0, 1'b0);
    run_op(16'h0038, 16'h0045, 1'b1, 1'b0, 1'b0);
    run_op(16'h1000, 16'h0001, 1'b1, 1'b0, 1'b0);
`endif
    for (int i = 0; i < 40; i++)
      run_op(rand_operand(1'b1), rand_operand(1'b1), 1'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));

    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0);
    reset_mid_run();
    run_op(16'h0907, 16'h0095, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
